char_glyph_memory: RTL and testbench

Parametrised multi-glyph bitmap store for the VGA character path. It holds NUM_GLYPHS monochrome glyphs of GLYPH_W x GLYPH_H pixels and serves one pixel per cycle to the scan-out logic through a fixed 2-cycle read pipeline. A serial loader lets the Arduino-side command decoder rewrite any glyph bit by bit while scan-out continues.

---
 rtl/char_mem_pkg.sv | 22 ++
 rtl/char_glyph_loader.sv | 105 ++++++++++
 rtl/char_glyph_memory.sv | 141 ++++++++++++++
 tb/tb_char_glyph_memory.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_mem_pkg.sv
// Shared types and helpers for the character glyph store.
//   load_state_e : serial loader states (idle, loading, done pulse)
//   clog2_min1   : address width for n entries, never below 1 bit
//   checker_bit  : reset value of cell (x, y) for a given base pattern
package char_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } load_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic checker_bit(input logic pattern, input int unsigned x,
                                         input int unsigned y);
        return pattern ^ (((x + y) % 2) == 1);
    endfunction

endpackage

// File: rtl/char_glyph_loader.sv
// Serial glyph loader: accepts one pixel per load_valid in raster order (x fastest) and
// produces single-cell write strobes for the glyph array.
// Ports:
//   clock, rst_n          : clock, asynchronous active-low reset
//   load_start/load_glyph : begin loading the given glyph (ignored unless idle / in range)
//   load_valid/load_bit   : next pixel
//   load_abort            : abandon the load; written cells are kept
//   load_busy, load_done  : loader in LOAD state / one-cycle completion pulse
//   wr_en, wr_glyph, wr_x, wr_y, wr_bit : write port to the glyph array
module char_glyph_loader
    import char_mem_pkg::*;
#(
    parameter int unsigned NUM_GLYPHS = 4,
    parameter int unsigned GLYPH_W    = 4,
    parameter int unsigned GLYPH_H    = 5,
    localparam int unsigned GW = clog2_min1(NUM_GLYPHS),
    localparam int unsigned XW = clog2_min1(GLYPH_W),
    localparam int unsigned YW = clog2_min1(GLYPH_H)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [GW-1:0] load_glyph,
    input  logic          load_valid,
    input  logic          load_bit,
    input  logic          load_abort,
    output logic          load_busy,
    output logic          load_done,
    output logic          wr_en,
    output logic [GW-1:0] wr_glyph,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic          wr_bit
);

    localparam logic [GW:0]   NumGlyphsExt = (GW + 1)'(NUM_GLYPHS);
    localparam logic [XW-1:0] LastX        = XW'(GLYPH_W - 1);
    localparam logic [YW-1:0] LastY        = YW'(GLYPH_H - 1);

    load_state_e   state_q;
    logic [GW-1:0] glyph_q;
    logic [XW-1:0] lx_q;
    logic [YW-1:0] ly_q;
    logic          start_ok;

    assign start_ok = ({1'b0, load_glyph} < NumGlyphsExt);

    // Abort has priority: a bit presented with load_abort is dropped.
    assign wr_en    = (state_q == StLoad) && load_valid && !load_abort;
    assign wr_glyph = glyph_q;
    assign wr_x     = lx_q;
    assign wr_y     = ly_q;
    assign wr_bit   = load_bit;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            glyph_q   <= '0;
            lx_q      <= '0;
            ly_q      <= '0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_start && start_ok) begin
                        glyph_q   <= load_glyph;
                        lx_q      <= '0;
                        ly_q      <= '0;
                        state_q   <= StLoad;
                        load_busy <= 1'b1;
                    end
                end
                StLoad: begin
                    if (load_abort) begin
                        state_q   <= StIdle;
                        load_busy <= 1'b0;
                    end else if (load_valid) begin
                        if (lx_q == LastX) begin
                            lx_q <= '0;
                            if (ly_q == LastY) begin
                                state_q   <= StDone;
                                load_busy <= 1'b0;
                                load_done <= 1'b1;
                            end else begin
                                ly_q <= ly_q + 1'b1;
                            end
                        end else begin
                            lx_q <= lx_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q   <= StIdle;
                    load_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/char_glyph_memory.sv
// Multi-glyph monochrome bitmap store with a fixed 2-cycle read pipeline and a serial
// loader that can rewrite any glyph while scan-out continues.
// Ports:
//   clock, rst_n                : clock, asynchronous active-low reset
//   rd_en, rd_glyph, rd_x, rd_y : read request (one per cycle, never stalls)
//   data_out, data_valid        : pixel and its valid, 2 cycles after rd_en
//   load_*                      : serial loader interface (see char_glyph_loader)
// Build option: CHAR_MEM_SPACING_EN blanks column GLYPH_W-1 on read (storage is unchanged).
module char_glyph_memory
    import char_mem_pkg::*;
#(
    parameter int unsigned NUM_GLYPHS    = 4,
    parameter int unsigned GLYPH_W       = 4,
    parameter int unsigned GLYPH_H       = 5,
    parameter logic        RESET_PATTERN = 1'b1,
    localparam int unsigned GW = clog2_min1(NUM_GLYPHS),
    localparam int unsigned XW = clog2_min1(GLYPH_W),
    localparam int unsigned YW = clog2_min1(GLYPH_H)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [GW-1:0] rd_glyph,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          data_out,
    output logic          data_valid,
    input  logic          load_start,
    input  logic [GW-1:0] load_glyph,
    input  logic          load_valid,
    input  logic          load_bit,
    input  logic          load_abort,
    output logic          load_busy,
    output logic          load_done
);

    localparam logic [GW:0] NumGlyphsExt = (GW + 1)'(NUM_GLYPHS);
    localparam logic [YW:0] HeightExt    = (YW + 1)'(GLYPH_H);
    localparam logic [XW:0] WidthExt     = (XW + 1)'(GLYPH_W);
`ifdef CHAR_MEM_SPACING_EN
    localparam logic [XW-1:0] LastX = XW'(GLYPH_W - 1);
`endif

    logic          wr_en;
    logic [GW-1:0] wr_glyph;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic          wr_bit;

    char_glyph_loader #(
        .NUM_GLYPHS (NUM_GLYPHS),
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H)
    ) u_loader (
        .clock      (clock),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_glyph (load_glyph),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_abort (load_abort),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .wr_en      (wr_en),
        .wr_glyph   (wr_glyph),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_bit     (wr_bit)
    );

    // One flop per cell so each gets its own constant checkerboard reset value.
    logic [GLYPH_W-1:0] rows [NUM_GLYPHS][GLYPH_H];

    for (genvar g = 0; g < NUM_GLYPHS; g++) begin : g_glyph
        for (genvar y = 0; y < GLYPH_H; y++) begin : g_row
            for (genvar x = 0; x < GLYPH_W; x++) begin : g_cell
                logic cell_q;
                logic cell_we;

                assign cell_we = wr_en && (wr_glyph == GW'(g)) && (wr_y == YW'(y))
                                 && (wr_x == XW'(x));

                always_ff @(posedge clock or negedge rst_n) begin
                    if (!rst_n) begin
                        cell_q <= checker_bit(RESET_PATTERN, x, y);
                    end else if (cell_we) begin
                        cell_q <= wr_bit;
                    end
                end

                assign rows[g][y][x] = cell_q;
            end
        end
    end

    // Stage 1: row select. Sampling before the write edge gives old-data on a same-cycle
    // read/write of one cell.
    logic [GLYPH_W-1:0] rd_row;
    logic [GLYPH_W-1:0] s1_row_q;
    logic [XW-1:0]      s1_x_q;
    logic               s1_valid_q;

    always_comb begin
        rd_row = '0;
        if (({1'b0, rd_glyph} < NumGlyphsExt) && ({1'b0, rd_y} < HeightExt)) begin
            rd_row = rows[rd_glyph][rd_y];
        end
    end

    // Stage 2: bit select.
    logic s2_bit;

    always_comb begin
        s2_bit = 1'b0;
        if ({1'b0, s1_x_q} < WidthExt) begin
            s2_bit = s1_row_q[s1_x_q];
        end
`ifdef CHAR_MEM_SPACING_EN
        if (s1_x_q == LastX) begin
            s2_bit = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_row_q   <= '0;
            s1_x_q     <= '0;
            s1_valid_q <= 1'b0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            s1_row_q   <= rd_row;
            s1_x_q     <= rd_x;
            s1_valid_q <= rd_en;
            data_out   <= s1_valid_q & s2_bit;
            data_valid <= s1_valid_q;
        end
    end

endmodule

// File: tb/tb_char_glyph_memory.sv
// Self-checking bench for char_glyph_memory (3 glyphs of 4x5). Read expectations come from
// a bench-side model of the array and are queued at issue time, then popped when
// data_valid appears.
module tb_char_glyph_memory;

    localparam int NG = 3;
    localparam int W  = 4;
    localparam int H  = 5;
    localparam int GW = 2;
    localparam int XW = 2;
    localparam int YW = 3;

    typedef struct {
        int   due;
        logic val;
        int   g;
        int   x;
        int   y;
    } exp_t;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [GW-1:0] rd_glyph;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          data_out;
    logic          data_valid;
    logic          load_start;
    logic [GW-1:0] load_glyph;
    logic          load_valid;
    logic          load_bit;
    logic          load_abort;
    logic          load_busy;
    logic          load_done;

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   done_seen = 0;
    int   ld_g      = 0;
    exp_t sb[$];
    logic model_q [NG][H][W];

    char_glyph_memory #(
        .NUM_GLYPHS    (NG),
        .GLYPH_W       (W),
        .GLYPH_H       (H),
        .RESET_PATTERN (1'b1)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_glyph   (rd_glyph),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .data_out   (data_out),
        .data_valid (data_valid),
        .load_start (load_start),
        .load_glyph (load_glyph),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_abort (load_abort),
        .load_busy  (load_busy),
        .load_done  (load_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clock) begin : mon
        exp_t e;
        logic exp_v;
        if (rst_n === 1'b1) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check_eq($sformatf("lost_read g%0d x%0d y%0d", e.g, e.x, e.y), 0, 1);
            end
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            if (data_valid || exp_v) check_eq("data_valid", {31'd0, data_valid}, {31'd0, exp_v});
            if (exp_v) begin
                e = sb.pop_front();
                check_eq($sformatf("data_out g%0d x%0d y%0d", e.g, e.x, e.y),
                         {31'd0, data_out}, {31'd0, e.val});
            end
            if (load_done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int g = 0; g < NG; g++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    model_q[g][y][x] = 1'b1 ^ (((x + y) % 2) == 1);
    endtask

    function automatic logic model_read(input int g, input int x, input int y);
        if (g >= NG || y >= H || x >= W) return 1'b0;
`ifdef CHAR_MEM_SPACING_EN
        if (x == W - 1) return 1'b0;
`endif
        return model_q[g][y][x];
    endfunction

    // Sets up a read for the next edge and queues its expected result.
    task automatic drive_read(input int g, input int x, input int y);
        exp_t e;
        rd_en    = 1'b1;
        rd_glyph = g[GW-1:0];
        rd_x     = x[XW-1:0];
        rd_y     = y[YW-1:0];
        e.due = cyc + 2;
        e.val = model_read(g, x, y);
        e.g   = g;
        e.x   = x;
        e.y   = y;
        sb.push_back(e);
    endtask

    task automatic drain();
        rd_en = 1'b0;
        repeat (3) tick();
        check_eq("sb_drain", sb.size(), 0);
    endtask

    task automatic read_glyph(input int g);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                drive_read(g, x, y);
                tick();
            end
        drain();
    endtask

    task automatic start_load(input int g);
        load_start = 1'b1;
        load_glyph = g[GW-1:0];
        ld_g       = g;
        tick();
        load_start = 1'b0;
    endtask

    // Presents cell idx for the next edge; caller issues any same-cycle read first.
    task automatic drive_bit(input int idx, input logic b);
        load_valid = 1'b1;
        load_bit   = b;
        model_q[ld_g][idx / W][idx % W] = b;
    endtask

    // Full glyph load of ones except cell zero_idx; optionally probes that cell in the
    // write cycle and in the cycle after.
    task automatic load_full(input int g, input int zero_idx, input bit probe);
        int d0;
        d0 = done_seen;
        start_load(g);
        check_eq("busy_after_start", {31'd0, load_busy}, 1);
        for (int i = 0; i < W * H; i++) begin
            if (probe && (i == zero_idx || i == zero_idx + 1))
                drive_read(g, zero_idx % W, zero_idx / W);
            if (i == 3) begin
                load_start = 1'b1;
                load_glyph = GW'((g + 1) % NG);
            end
            drive_bit(i, (i == zero_idx) ? 1'b0 : 1'b1);
            tick();
            rd_en      = 1'b0;
            load_start = 1'b0;
            if (i == 9) begin
                load_valid = 1'b0;
                tick();
            end
            if (i < W * H - 1) begin
                check_eq("busy_during_load", {31'd0, load_busy}, 1);
                check_eq("no_early_done", {31'd0, load_done}, 0);
            end
        end
        load_valid = 1'b0;
        check_eq("load_done_pulse", {31'd0, load_done}, 1);
        check_eq("busy_in_done", {31'd0, load_busy}, 0);
        tick();
        check_eq("load_done_cleared", {31'd0, load_done}, 0);
        check_eq("done_pulse_count", done_seen, d0 + 1);
        drain();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst_n      = 1'b1;
        rd_en      = 1'b0;
        rd_glyph   = '0;
        rd_x       = '0;
        rd_y       = '0;
        load_start = 1'b0;
        load_glyph = '0;
        load_valid = 1'b0;
        load_bit   = 1'b0;
        load_abort = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_data_out", {31'd0, data_out}, 0);
        check_eq("rst_data_valid", {31'd0, data_valid}, 0);
        check_eq("rst_load_busy", {31'd0, load_busy}, 0);
        check_eq("rst_load_done", {31'd0, load_done}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic back-to-back reads of glyph 0.
        drive_read(0, 0, 0); tick();
        drive_read(0, 1, 0); tick();
        drive_read(0, 0, 1); tick();
        drain();
        for (int g = 0; g < NG; g++) read_glyph(g);

        // Full load of glyph 2 with ones.
        load_full(2, -1, 1'b0);
        read_glyph(2);
        read_glyph(1);

        // Abort glyph 1 after 7 zero bits; the abort-cycle bit must not land.
        d0 = done_seen;
        start_load(1);
        for (int i = 0; i < 7; i++) begin
            drive_bit(i, 1'b0);
            tick();
        end
        load_valid = 1'b1;
        load_bit   = 1'b0;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        check_eq("busy_after_abort", {31'd0, load_busy}, 0);
        tick();
        load_valid = 1'b0;
        tick();
        check_eq("no_done_on_abort", done_seen, d0);
        read_glyph(1);

        // Out-of-range reads and an out-of-range load request.
        drive_read(0, 0, 5); tick();
        drive_read(3, 0, 0); tick();
        drive_read(1, 2, 7); tick();
        drain();
        load_start = 1'b1;
        load_glyph = 2'd3;
        tick();
        load_start = 1'b0;
        check_eq("busy_bad_glyph", {31'd0, load_busy}, 0);
        load_valid = 1'b1;
        load_bit   = 1'b0;
        tick();
        load_valid = 1'b0;
        read_glyph(0);

        // Glyph 0: same-cycle read/write of (1,1), then next-cycle read.
        load_full(0, 5, 1'b1);
        read_glyph(0);
        read_glyph(2);

        // Reset in the middle of a load.
        start_load(1);
        for (int i = 0; i < 3; i++) begin
            drive_bit(i, 1'b0);
            tick();
        end
        load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("busy_async_rst", {31'd0, load_busy}, 0);
        check_eq("valid_async_rst", {31'd0, data_valid}, 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int g = 0; g < NG; g++) read_glyph(g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
